commit_stage: RTL and testbench

//  In-order retirement stage directly downstream of the reorder buffer (ROB).

---
 rtl/commit_stage.sv | 231 +++++++++++++++++++++++
 tb/tb_commit_stage.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/commit_stage.sv
// In-order retirement stage at the ROB head: pops completed entries, publishes
// architectural/store/PHT updates and sequences exception and mispredict flushes.
module commit_stage #(
  parameter int ROB_ADDR_W = 4,
  parameter int ADDR_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int GHR_W      = 5,
  parameter int EXC_W      = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  can_commit,
  input  logic                  done_in,
  input  logic [ROB_ADDR_W-1:0] rob_addr_in,
  input  logic                  reg_write_en_in,
  input  logic [REG_ADDR_W-1:0] reg_write_addr_in,
  input  logic                  mem_write_flag_in,
  input  logic                  is_branch_in,
  input  logic                  pred_taken_in,
  input  logic                  act_taken_in,
  input  logic [ADDR_W-1:0]     target_in,
  input  logic [GHR_W-1:0]      pht_index_in,
  input  logic                  is_delayslot_in,
  input  logic [EXC_W-1:0]      exc_type_in,
  input  logic [ADDR_W-1:0]     pc_in,
  input  logic                  store_ack,
  output logic                  commit_en,
  output logic                  arch_we,
  output logic [REG_ADDR_W-1:0] arch_waddr,
  output logic [ROB_ADDR_W-1:0] arch_rob_addr,
  output logic                  store_req,
  output logic                  pht_update,
  output logic [GHR_W-1:0]      pht_index,
  output logic                  pht_taken,
  output logic                  exc_req,
  output logic [EXC_W-1:0]      exc_type,
  output logic [ADDR_W-1:0]     exc_pc,
  output logic                  exc_delayslot,
  output logic                  flush,
  output logic [ADDR_W-1:0]     redirect_pc
);

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    STORE_WAIT = 2'd1,
    DSLOT      = 2'd2,
    FLUSH      = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(8);

  state_t                  r_state, w_state_nxt;
  logic                    r_arch_we, w_arch_we;
  logic [REG_ADDR_W-1:0]   r_arch_waddr, w_arch_waddr;
  logic [ROB_ADDR_W-1:0]   r_arch_rob_addr, w_arch_rob_addr;
  logic                    r_store_req, w_store_req;
  logic                    r_pht_update, w_pht_update;
  logic [GHR_W-1:0]        r_pht_index, w_pht_index;
  logic                    r_pht_taken, w_pht_taken;
  logic                    r_exc_req, w_exc_req;
  logic [EXC_W-1:0]        r_exc_type, w_exc_type;
  logic [ADDR_W-1:0]       r_exc_pc, w_exc_pc;
  logic                    r_exc_delayslot, w_exc_delayslot;
  logic                    r_flush, w_flush;
  logic [ADDR_W-1:0]       r_redirect_pc, w_redirect_pc;
  logic [ADDR_W-1:0]       r_redirect_tgt, w_redirect_tgt;
  logic                    w_commit_en;
  logic                    w_ready;
  logic                    w_has_exc;
  logic                    w_we_head;

  assign w_ready   = can_commit & done_in;
  assign w_has_exc = (exc_type_in != '0);
  // GPR 0 is hard-wired, so writes to it never reach the architectural state.
  assign w_we_head = reg_write_en_in & (reg_write_addr_in != '0);

  // Next-state, pop decision and next values of every registered output.
  always_comb begin
    w_state_nxt     = r_state;
    w_commit_en     = 1'b0;
    w_arch_we       = 1'b0;
    w_arch_waddr    = '0;
    w_arch_rob_addr = '0;
    w_store_req     = 1'b0;
    w_pht_update    = 1'b0;
    w_pht_index     = '0;
    w_pht_taken     = 1'b0;
    w_exc_req       = 1'b0;
    w_exc_type      = r_exc_type;
    w_exc_pc        = r_exc_pc;
    w_exc_delayslot = r_exc_delayslot;
    w_flush         = 1'b0;
    w_redirect_pc   = '0;
    w_redirect_tgt  = r_redirect_tgt;

    case (r_state)
      RUN: begin
        if (w_ready && w_has_exc) begin
          w_commit_en     = 1'b1;
          w_exc_req       = 1'b1;
          w_exc_type      = exc_type_in;
          w_exc_pc        = pc_in;
          w_exc_delayslot = is_delayslot_in;
          w_flush         = 1'b1;
          w_state_nxt     = FLUSH;
        end else if (w_ready && mem_write_flag_in) begin
          // The store stays at the head until the store buffer accepts it.
          w_store_req = 1'b1;
          w_state_nxt = STORE_WAIT;
        end else if (w_ready) begin
          w_commit_en = 1'b1;
          if (w_we_head) begin
            w_arch_we       = 1'b1;
            w_arch_waddr    = reg_write_addr_in;
            w_arch_rob_addr = rob_addr_in;
          end else begin
            w_arch_we = 1'b0;
          end
          if (is_branch_in) begin
            w_pht_update = 1'b1;
            w_pht_index  = pht_index_in;
            w_pht_taken  = act_taken_in;
          end else begin
            w_pht_update = 1'b0;
          end
          if (is_branch_in && (pred_taken_in != act_taken_in)) begin
            w_redirect_tgt = act_taken_in ? target_in : (pc_in + PC_STEP);
            w_state_nxt    = DSLOT;
          end else begin
            w_state_nxt = RUN;
          end
        end else begin
          w_state_nxt = RUN;
        end
      end
      STORE_WAIT: begin
        if (store_ack) begin
          w_commit_en = 1'b1;
          w_state_nxt = RUN;
        end else begin
          w_store_req = 1'b1;
        end
      end
      DSLOT: begin
        if (w_ready && w_has_exc) begin
          // A faulting delay slot overrides the pending branch redirect.
          w_commit_en     = 1'b1;
          w_exc_req       = 1'b1;
          w_exc_type      = exc_type_in;
          w_exc_pc        = pc_in;
          w_exc_delayslot = 1'b1;
          w_flush         = 1'b1;
          w_state_nxt     = FLUSH;
        end else if (w_ready) begin
          w_commit_en = 1'b1;
          if (w_we_head) begin
            w_arch_we       = 1'b1;
            w_arch_waddr    = reg_write_addr_in;
            w_arch_rob_addr = rob_addr_in;
          end else begin
            w_arch_we = 1'b0;
          end
          w_flush       = 1'b1;
          w_redirect_pc = r_redirect_tgt;
          w_state_nxt   = FLUSH;
        end else begin
          w_state_nxt = DSLOT;
        end
      end
      FLUSH: begin
        w_state_nxt = RUN;
      end
      default: begin
        w_state_nxt = RUN;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state         <= RUN;
      r_arch_we       <= 1'b0;
      r_arch_waddr    <= '0;
      r_arch_rob_addr <= '0;
      r_store_req     <= 1'b0;
      r_pht_update    <= 1'b0;
      r_pht_index     <= '0;
      r_pht_taken     <= 1'b0;
      r_exc_req       <= 1'b0;
      r_exc_type      <= '0;
      r_exc_pc        <= '0;
      r_exc_delayslot <= 1'b0;
      r_flush         <= 1'b0;
      r_redirect_pc   <= '0;
      r_redirect_tgt  <= '0;
    end else begin
      r_state         <= w_state_nxt;
      r_arch_we       <= w_arch_we;
      r_arch_waddr    <= w_arch_waddr;
      r_arch_rob_addr <= w_arch_rob_addr;
      r_store_req     <= w_store_req;
      r_pht_update    <= w_pht_update;
      r_pht_index     <= w_pht_index;
      r_pht_taken     <= w_pht_taken;
      r_exc_req       <= w_exc_req;
      r_exc_type      <= w_exc_type;
      r_exc_pc        <= w_exc_pc;
      r_exc_delayslot <= w_exc_delayslot;
      r_flush         <= w_flush;
      r_redirect_pc   <= w_redirect_pc;
      r_redirect_tgt  <= w_redirect_tgt;
    end
  end

  assign commit_en     = w_commit_en;
  assign arch_we       = r_arch_we;
  assign arch_waddr    = r_arch_waddr;
  assign arch_rob_addr = r_arch_rob_addr;
  assign store_req     = r_store_req;
  assign pht_update    = r_pht_update;
  assign pht_index     = r_pht_index;
  assign pht_taken     = r_pht_taken;
  assign exc_req       = r_exc_req;
  assign exc_type      = r_exc_type;
  assign exc_pc        = r_exc_pc;
  assign exc_delayslot = r_exc_delayslot;
  assign flush         = r_flush;
  assign redirect_pc   = r_redirect_pc;

endmodule

// File: tb/tb_commit_stage.sv
// Self-checking bench for commit_stage: vector table, directed multi-cycle
// sequences and randomized traffic against a transaction-level reference model.
module tb_commit_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        can_commit, done_in, reg_write_en_in, mem_write_flag_in;
  logic        is_branch_in, pred_taken_in, act_taken_in, is_delayslot_in;
  logic        store_ack;
  logic [3:0]  rob_addr_in;
  logic [4:0]  reg_write_addr_in, pht_index_in;
  logic [31:0] target_in, pc_in;
  logic [7:0]  exc_type_in;
  logic        commit_en, arch_we, store_req, pht_update, pht_taken;
  logic        exc_req, exc_delayslot, flush;
  logic [4:0]  arch_waddr, pht_index;
  logic [3:0]  arch_rob_addr;
  logic [7:0]  exc_type;
  logic [31:0] exc_pc, redirect_pc;

  int total = 0;
  int bad = 0;

  commit_stage dut (
    .clk(clk), .rst(rst), .can_commit(can_commit), .done_in(done_in),
    .rob_addr_in(rob_addr_in), .reg_write_en_in(reg_write_en_in),
    .reg_write_addr_in(reg_write_addr_in), .mem_write_flag_in(mem_write_flag_in),
    .is_branch_in(is_branch_in), .pred_taken_in(pred_taken_in),
    .act_taken_in(act_taken_in), .target_in(target_in), .pht_index_in(pht_index_in),
    .is_delayslot_in(is_delayslot_in), .exc_type_in(exc_type_in), .pc_in(pc_in),
    .store_ack(store_ack), .commit_en(commit_en), .arch_we(arch_we),
    .arch_waddr(arch_waddr), .arch_rob_addr(arch_rob_addr), .store_req(store_req),
    .pht_update(pht_update), .pht_index(pht_index), .pht_taken(pht_taken),
    .exc_req(exc_req), .exc_type(exc_type), .exc_pc(exc_pc),
    .exc_delayslot(exc_delayslot), .flush(flush), .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       cc, done, we;
    logic [4:0] waddr;
    logic [3:0] rob;
    logic       br, pred, act;
    logic [4:0] idx;
    logic       exp_ce, exp_we;
    logic [4:0] exp_waddr;
    logic       exp_pht, exp_taken;
  } vec_t;

  vec_t vecs [6];

  // reference model state: pending store, pending delay slot, one bubble
  bit          m_store_pending, m_dslot, m_bubble, m_ce;
  logic [31:0] m_redir;
  logic        m_we, m_sreq, m_pht, m_ptaken, m_excr, m_flush, m_eds;
  logic [4:0]  m_waddr, m_pidx;
  logic [3:0]  m_rob;
  logic [7:0]  m_etype;
  logic [31:0] m_epc, m_rpc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    can_commit = 1'b0; done_in = 1'b0; rob_addr_in = 4'd0; reg_write_en_in = 1'b0;
    reg_write_addr_in = 5'd0; mem_write_flag_in = 1'b0; is_branch_in = 1'b0;
    pred_taken_in = 1'b0; act_taken_in = 1'b0; target_in = 32'd0; pht_index_in = 5'd0;
    is_delayslot_in = 1'b0; exc_type_in = 8'd0; pc_in = 32'd0; store_ack = 1'b0;
  endtask

  task automatic alu_head(input logic [4:0] waddr, input logic [3:0] rob);
    set_idle();
    can_commit = 1'b1; done_in = 1'b1; reg_write_en_in = 1'b1;
    reg_write_addr_in = waddr; rob_addr_in = rob;
  endtask

  // Mispredicted branch, its delay slot, then the flush/redirect and bubble.
  task automatic misp_seq(input logic [31:0] pc, input logic pred, input logic act,
                          input logic [31:0] tgt, input logic [31:0] exp_rpc);
    set_idle();
    can_commit = 1'b1; done_in = 1'b1; is_branch_in = 1'b1; pred_taken_in = pred;
    act_taken_in = act; target_in = tgt; pc_in = pc; pht_index_in = 5'd7;
    @(negedge clk); check("br_ce", commit_en, 1);
    cyc();
    alu_head(5'd9, 4'd5); is_delayslot_in = 1'b1; pc_in = pc + 32'd4;
    @(negedge clk);
    check("br_pht", pht_update, 1); check("br_ptaken", pht_taken, act);
    check("br_pidx", pht_index, 7); check("ds_ce", commit_en, 1); check("ds_noflush", flush, 0);
    cyc();
    alu_head(5'd10, 4'd6);
    @(negedge clk);
    check("fl_flush", flush, 1); check("fl_rpc", redirect_pc, exp_rpc);
    check("ds_we", arch_we, 1); check("ds_waddr", arch_waddr, 9);
    check("fl_bubble_ce", commit_en, 0); check("fl_pht_pulse", pht_update, 0);
    cyc();
    @(negedge clk);
    check("post_flush", flush, 0); check("post_rpc", redirect_pc, 0); check("post_ce", commit_en, 1);
    cyc();
    set_idle();
    @(negedge clk); check("post_we", arch_we, 1); check("post_waddr", arch_waddr, 10);
    cyc();
  endtask

  task automatic model_step();
    bit rdy;
    rdy = can_commit && done_in;
    m_ce = 1'b0; m_we = 1'b0; m_waddr = 5'd0; m_rob = 4'd0; m_pht = 1'b0; m_pidx = 5'd0;
    m_ptaken = 1'b0; m_excr = 1'b0; m_flush = 1'b0; m_rpc = 32'd0;
    if (m_bubble) begin
      m_bubble = 1'b0;
    end else if (m_store_pending) begin
      if (store_ack) begin m_ce = 1'b1; m_store_pending = 1'b0; end
    end else if (rdy) begin
      if (exc_type_in != 8'd0) begin
        m_ce = 1'b1; m_excr = 1'b1; m_etype = exc_type_in; m_epc = pc_in;
        m_eds = m_dslot ? 1'b1 : is_delayslot_in;
        m_flush = 1'b1; m_dslot = 1'b0; m_bubble = 1'b1;
      end else if (m_dslot || !mem_write_flag_in) begin
        m_ce = 1'b1;
        if (reg_write_en_in && reg_write_addr_in != 5'd0) begin
          m_we = 1'b1; m_waddr = reg_write_addr_in; m_rob = rob_addr_in;
        end
        if (m_dslot) begin
          m_flush = 1'b1; m_rpc = m_redir; m_dslot = 1'b0; m_bubble = 1'b1;
        end else if (is_branch_in) begin
          m_pht = 1'b1; m_pidx = pht_index_in; m_ptaken = act_taken_in;
          if (pred_taken_in != act_taken_in) begin
            m_dslot = 1'b1;
            m_redir = act_taken_in ? target_in : pc_in + 32'd8;
          end
        end
      end else begin
        m_store_pending = 1'b1;
      end
    end
    m_sreq = m_store_pending;
  endtask

  initial begin
    vecs[0] = '{1'b1, 1'b1, 1'b1, 5'd5,  4'd3, 1'b0, 1'b0, 1'b0, 5'd0,  1'b1, 1'b1, 5'd5,  1'b0, 1'b0};
    vecs[1] = '{1'b1, 1'b1, 1'b1, 5'd0,  4'd7, 1'b0, 1'b0, 1'b0, 5'd0,  1'b1, 1'b0, 5'd0,  1'b0, 1'b0};
    vecs[2] = '{1'b1, 1'b0, 1'b1, 5'd6,  4'd1, 1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 5'd0,  1'b0, 1'b0};
    vecs[3] = '{1'b0, 1'b1, 1'b1, 5'd6,  4'd2, 1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 5'd0,  1'b0, 1'b0};
    vecs[4] = '{1'b1, 1'b1, 1'b1, 5'd31, 4'd9, 1'b1, 1'b1, 1'b1, 5'd12, 1'b1, 1'b1, 5'd31, 1'b1, 1'b1};
    vecs[5] = '{1'b1, 1'b1, 1'b0, 5'd4,  4'd4, 1'b1, 1'b0, 1'b0, 5'd3,  1'b1, 1'b0, 5'd0,  1'b1, 1'b0};

    set_idle();
    rst = 1'b0;
    cyc(); cyc();
    @(negedge clk);
    check("rst_arch_we", arch_we, 0); check("rst_store_req", store_req, 0);
    check("rst_pht", pht_update, 0); check("rst_exc", exc_req, 0);
    check("rst_flush", flush, 0); check("rst_rpc", redirect_pc, 0);
    check("rst_exc_pc", exc_pc, 0); check("rst_waddr", arch_waddr, 0);
    cyc();
    rst = 1'b1;

    for (int i = 0; i < 6; i++) begin
      set_idle();
      can_commit = vecs[i].cc; done_in = vecs[i].done; reg_write_en_in = vecs[i].we;
      reg_write_addr_in = vecs[i].waddr; rob_addr_in = vecs[i].rob; is_branch_in = vecs[i].br;
      pred_taken_in = vecs[i].pred; act_taken_in = vecs[i].act; pht_index_in = vecs[i].idx;
      @(negedge clk); check($sformatf("vec%0d_ce", i), commit_en, vecs[i].exp_ce);
      cyc();
      set_idle();
      @(negedge clk);
      check($sformatf("vec%0d_we", i), arch_we, vecs[i].exp_we);
      check($sformatf("vec%0d_waddr", i), arch_waddr, vecs[i].exp_waddr);
      if (vecs[i].exp_we) check($sformatf("vec%0d_rob", i), arch_rob_addr, vecs[i].rob);
      check($sformatf("vec%0d_pht", i), pht_update, vecs[i].exp_pht);
      check($sformatf("vec%0d_ptaken", i), pht_taken, vecs[i].exp_taken);
      if (vecs[i].exp_pht) check($sformatf("vec%0d_pidx", i), pht_index, vecs[i].idx);
      cyc();
    end

    // head not done for three cycles
    alu_head(5'd5, 4'd3); done_in = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); check("notdone_ce", commit_en, 0); check("notdone_we", arch_we, 0);
      cyc();
    end

    // store held for three cycles without ack
    set_idle(); can_commit = 1'b1; done_in = 1'b1; mem_write_flag_in = 1'b1;
    @(negedge clk); check("st_run_ce", commit_en, 0);
    cyc();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); check("st_wait_req", store_req, 1); check("st_wait_ce", commit_en, 0);
      cyc();
    end
    store_ack = 1'b1;
    @(negedge clk); check("st_ack_req", store_req, 1); check("st_ack_ce", commit_en, 1);
    cyc();
    set_idle();
    @(negedge clk); check("st_done_req", store_req, 0); check("st_done_ce", commit_en, 0);
    cyc();

    misp_seq(32'hbfc00010, 1'b0, 1'b1, 32'hbfc00100, 32'hbfc00100);
    misp_seq(32'h00000100, 1'b1, 1'b0, 32'h00000400, 32'h00000108);
    misp_seq(32'hfffffffc, 1'b1, 1'b0, 32'h00000400, 32'h00000004);

    // delay slot raises an exception
    set_idle(); can_commit = 1'b1; done_in = 1'b1; is_branch_in = 1'b1;
    act_taken_in = 1'b1; target_in = 32'hbfc00200; pc_in = 32'hbfc00040;
    cyc();
    alu_head(5'd3, 4'd2); is_delayslot_in = 1'b1; exc_type_in = 8'h04; pc_in = 32'hbfc00044;
    @(negedge clk); check("dsx_ce", commit_en, 1);
    cyc();
    set_idle();
    @(negedge clk);
    check("dsx_req", exc_req, 1); check("dsx_type", exc_type, 8'h04);
    check("dsx_pc", exc_pc, 32'hbfc00044); check("dsx_ds", exc_delayslot, 1);
    check("dsx_flush", flush, 1); check("dsx_rpc", redirect_pc, 0); check("dsx_we", arch_we, 0);
    cyc();
    @(negedge clk); check("dsx_pulse", exc_req, 0); check("dsx_flush_pulse", flush, 0);
    cyc();

    // asynchronous reset while waiting on a store
    set_idle(); can_commit = 1'b1; done_in = 1'b1; mem_write_flag_in = 1'b1;
    cyc();
    #2; check("rst_mid_pre", store_req, 1);
    rst = 1'b0;
    #1; check("rst_mid_req", store_req, 0);
    cyc();
    rst = 1'b1;
    alu_head(5'd2, 4'd1);
    @(negedge clk); check("rst_mid_run_ce", commit_en, 1);
    cyc();

    // randomized traffic against the reference model
    set_idle(); rst = 1'b0;
    cyc();
    rst = 1'b1;
    m_store_pending = 0; m_dslot = 0; m_bubble = 0; m_redir = 32'd0;
    m_we = 0; m_waddr = 0; m_rob = 0; m_sreq = 0; m_pht = 0; m_pidx = 0; m_ptaken = 0;
    m_excr = 0; m_flush = 0; m_rpc = 0; m_etype = 0; m_epc = 0; m_eds = 0;
    for (int n = 0; n < 400; n++) begin
      can_commit = ($urandom_range(0, 7) != 0); done_in = ($urandom_range(0, 3) != 0);
      reg_write_en_in = $urandom_range(0, 1); reg_write_addr_in = 5'($urandom);
      rob_addr_in = 4'($urandom); mem_write_flag_in = ($urandom_range(0, 5) == 0);
      is_branch_in = ($urandom_range(0, 3) == 0); pred_taken_in = $urandom_range(0, 1);
      act_taken_in = $urandom_range(0, 1); target_in = $urandom; pc_in = $urandom;
      pht_index_in = 5'($urandom); is_delayslot_in = $urandom_range(0, 1);
      exc_type_in = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(1, 255)) : 8'd0;
      store_ack = $urandom_range(0, 1);
      @(negedge clk);
      check("rnd_we", arch_we, m_we); check("rnd_waddr", arch_waddr, m_waddr);
      check("rnd_rob", arch_rob_addr, m_rob); check("rnd_sreq", store_req, m_sreq);
      check("rnd_pht", pht_update, m_pht); check("rnd_pidx", pht_index, m_pidx);
      check("rnd_ptaken", pht_taken, m_ptaken); check("rnd_exc", exc_req, m_excr);
      check("rnd_flush", flush, m_flush); check("rnd_rpc", redirect_pc, m_rpc);
      if (m_excr) begin
        check("rnd_etype", exc_type, m_etype); check("rnd_epc", exc_pc, m_epc);
        check("rnd_eds", exc_delayslot, m_eds);
      end
      model_step();
      check("rnd_ce", commit_en, m_ce);
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
